// File: rtl/draw_image.sv
// Image ROM reader and sprite overlay for the VGA stream; 3-clock aligned pipeline.
// Optional colour-key transparency: define DRAW_IMAGE_TRANSPARENCY_EN.
module draw_image #(
    parameter int          IMG_WIDTH  = 128,
    parameter int          IMG_HEIGHT = 128,
    parameter int          ADDR_WIDTH = 14,
    parameter logic [11:0] KEY_COLOUR = 12'h000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [11:0]           hcount_in,
    input  logic [11:0]           vcount_in,
    input  logic                  hsync_in,
    input  logic                  vsync_in,
    input  logic                  hblnk_in,
    input  logic                  vblnk_in,
    input  logic [11:0]           rgb_in,
    input  logic [11:0]           xpos,
    input  logic [11:0]           ypos,
    input  logic [11:0]           pixel_data,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [11:0]           hcount_out,
    output logic [11:0]           vcount_out,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic                  hblnk_out,
    output logic                  vblnk_out,
    output logic [11:0]           rgb_out
);

`ifdef DRAW_IMAGE_TRANSPARENCY_EN
    localparam logic KEY_EN = 1'b1;
`else
    localparam logic KEY_EN = 1'b0;
`endif

    typedef struct packed {
        logic [11:0] hcount;
        logic [11:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
        logic [11:0] rgb;
        logic        in_win;
    } px_t;

    logic [11:0]           xl, yl;
    logic                  vblnk_prev;
    logic [11:0]           dx, dy;
    logic                  in_win_c;
    logic [ADDR_WIDTH-1:0] addr_c;
    px_t                   pix_p1, pix_p2;

    function automatic logic [11:0] composite(input logic draw, input logic [11:0] pix,
                                              input logic [11:0] bg);
        if (draw && !(KEY_EN && pix == KEY_COLOUR))
            return pix;
        return bg;
    endfunction

    // Window test in 13 bits so a sprite near the right/bottom limit never wraps to 0.
    always_comb begin
        dx       = hcount_in - xl;
        dy       = vcount_in - yl;
        in_win_c = ({1'b0, hcount_in} >= {1'b0, xl}) &&
                   ({1'b0, hcount_in} <  ({1'b0, xl} + 13'(IMG_WIDTH))) &&
                   ({1'b0, vcount_in} >= {1'b0, yl}) &&
                   ({1'b0, vcount_in} <  ({1'b0, yl} + 13'(IMG_HEIGHT)));
        addr_c   = in_win_c ? ADDR_WIDTH'(32'(dy) * 32'(IMG_WIDTH) + 32'(dx)) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xl         <= '0;
            yl         <= '0;
            vblnk_prev <= 1'b0;
            pix_p1     <= '0;
            pix_p2     <= '0;
            address    <= '0;
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            // Position only moves at the start of vblank, so a frame never tears.
            vblnk_prev <= vblnk_in;
            if (vblnk_in && !vblnk_prev) begin
                xl <= xpos;
                yl <= ypos;
            end

            // Stage 1: ROM address issued, stream delayed once
            address       <= addr_c;
            pix_p1.hcount <= hcount_in;
            pix_p1.vcount <= vcount_in;
            pix_p1.hsync  <= hsync_in;
            pix_p1.vsync  <= vsync_in;
            pix_p1.hblnk  <= hblnk_in;
            pix_p1.vblnk  <= vblnk_in;
            pix_p1.rgb    <= rgb_in;
            pix_p1.in_win <= in_win_c;

            // Stage 2: ROM read in flight
            pix_p2 <= pix_p1;

            // Stage 3: overlay ROM colour onto background
            hcount_out <= pix_p2.hcount;
            vcount_out <= pix_p2.vcount;
            hsync_out  <= pix_p2.hsync;
            vsync_out  <= pix_p2.vsync;
            hblnk_out  <= pix_p2.hblnk;
            vblnk_out  <= pix_p2.vblnk;
            rgb_out    <= composite(pix_p2.in_win && !pix_p2.hblnk && !pix_p2.vblnk,
                                    pixel_data, pix_p2.rgb);
        end
    end

endmodule
